// File: rtl/sensor_sampler.sv
// sensor_sampler: collects one frame of 8 ADC channel samples and publishes it to the sensor controller.
// Optional per-channel averaging of 2**AVG_LOG2 samples is built when SENSOR_AVG_EN is defined.
module sensor_sampler #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensor_en,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic [2:0]        adc_chan,
    output logic              sensor_ready,
    output logic              sensor_ovr,
    output logic [31:0]       sensor_out_0,
    output logic [31:0]       sensor_out_1,
    output logic [31:0]       sensor_out_2,
    output logic [31:0]       sensor_out_3,
    output logic [31:0]       sensor_out_4,
    output logic [31:0]       sensor_out_5,
    output logic [31:0]       sensor_out_6,
    output logic [31:0]       sensor_out_7
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_SETTLE  = 2'd2;
    localparam logic [1:0] ST_READY   = 2'd3;

    // Reject parameter values the datapath cannot represent
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("sensor_sampler: DATA_W must be 1..32");
    end
    if (AVG_LOG2 > 8) begin : g_bad_avg_log2
        $error("sensor_sampler: AVG_LOG2 must be 0..8");
    end

    logic [1:0]       state_q, state_d;
    logic [2:0]       chan_q, chan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             ovr_q, ovr_d;
    logic [31:0]      cap_q [8];
    logic [31:0]      cap_d [8];
    logic [31:0]      out_q [8];
    logic [31:0]      out_d [8];
    logic             ch_done;
    logic             publish;

`ifdef SENSOR_AVG_EN
    localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
    localparam int unsigned SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [SCNT_W-1:0] samp_q, samp_d;
    logic              last_samp;

    // Running sum including the sample presented this cycle
    assign acc_sum   = acc_q + ACC_W'(adc_data);
    assign last_samp = (samp_q == SCNT_W'((1 << AVG_LOG2) - 1));
`endif

    // Next-state and datapath update for the capture FSM
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        cap_d   = cap_q;
        out_d   = out_q;
        ch_done = 1'b0;
        publish = 1'b0;
`ifdef SENSOR_AVG_EN
        acc_d   = acc_q;
        samp_d  = samp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (adc_valid) ovr_d = 1'b1;
                if (sensor_en) begin
                    state_d = ST_COLLECT;
                    chan_d  = 3'd0;
                    ovr_d   = 1'b0;
`ifdef SENSOR_AVG_EN
                    acc_d   = '0;
                    samp_d  = '0;
`endif
                end
            end
            ST_COLLECT: begin
                if (!sensor_en) begin
                    // Abort: partial frame is simply never published
                    state_d = ST_IDLE;
                    chan_d  = 3'd0;
`ifdef SENSOR_AVG_EN
                    acc_d   = '0;
                    samp_d  = '0;
`endif
                end else if (adc_valid) begin
`ifdef SENSOR_AVG_EN
                    if (last_samp) begin
                        cap_d[chan_q] = 32'(DATA_W'(acc_sum >> AVG_LOG2));
                        acc_d         = '0;
                        samp_d        = '0;
                        ch_done       = 1'b1;
                    end else begin
                        acc_d  = acc_sum;
                        samp_d = samp_q + SCNT_W'(1);
                    end
`else
                    cap_d[chan_q] = 32'(adc_data);
                    ch_done       = 1'b1;
`endif
                end
                if (ch_done) begin
                    chan_d = chan_q + 3'd1;
                    if (chan_q == 3'd7) begin
                        if (SETTLE_CYCLES > 0) begin
                            state_d = ST_SETTLE;
                            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        end else begin
                            publish = 1'b1;
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (adc_valid) ovr_d = 1'b1;
                if (!sensor_en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    publish = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READY: begin
                if (adc_valid) ovr_d = 1'b1;
                if (!sensor_en) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Publish uses cap_d so a zero-settle frame includes the ch7 sample just taken
        if (publish) begin
            state_d = ST_READY;
            ready_d = 1'b1;
            out_d   = cap_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            chan_q  <= 3'd0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            cap_q   <= '{default: '0};
            out_q   <= '{default: '0};
`ifdef SENSOR_AVG_EN
            acc_q   <= '0;
            samp_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
`ifdef SENSOR_AVG_EN
            acc_q   <= acc_d;
            samp_q  <= samp_d;
`endif
        end
    end

    assign adc_chan     = chan_q;
    assign sensor_ready = ready_q;
    assign sensor_ovr   = ovr_q;
    assign sensor_out_0 = out_q[0];
    assign sensor_out_1 = out_q[1];
    assign sensor_out_2 = out_q[2];
    assign sensor_out_3 = out_q[3];
    assign sensor_out_4 = out_q[4];
    assign sensor_out_5 = out_q[5];
    assign sensor_out_6 = out_q[6];
    assign sensor_out_7 = out_q[7];

endmodule
